// File: rtl/sdes_pkg.sv
// Shared S-DES definitions for the block controller: sequencer states, permutation and
// S-box tables, and the IP / IP^-1 / SW helpers.
package sdes_pkg;

   typedef enum logic [2:0] {
      StNoKey,
      StKeyGen,
      StReady,
      StR1,
      StR2,
      StDone
   } state_e;

   // Table entries are 1-based S-DES bit positions, position 1 being the MSB.
   localparam int IP_TBL     [8] = '{2, 6, 3, 1, 4, 8, 5, 7};
   localparam int IP_INV_TBL [8] = '{4, 1, 3, 5, 7, 2, 8, 6};
   localparam int EP_TBL     [8] = '{4, 1, 2, 3, 2, 3, 4, 1};
   localparam int P4_TBL     [4] = '{2, 4, 3, 1};

   // S-boxes indexed by {row, col} = {b1, b4, b2, b3} of the 4-bit input.
   localparam logic [1:0] S0_TBL [16] = '{
      2'd1, 2'd0, 2'd3, 2'd2,
      2'd3, 2'd2, 2'd1, 2'd0,
      2'd0, 2'd2, 2'd1, 2'd3,
      2'd3, 2'd1, 2'd3, 2'd2
   };
   localparam logic [1:0] S1_TBL [16] = '{
      2'd0, 2'd1, 2'd2, 2'd3,
      2'd2, 2'd0, 2'd1, 2'd3,
      2'd3, 2'd0, 2'd1, 2'd0,
      2'd2, 2'd1, 2'd0, 2'd3
   };

   function automatic logic [7:0] ip(input logic [7:0] x);
      logic [7:0] r;
      r = '0;
      for (int i = 0; i < 8; i++) r[7-i] = x[8-IP_TBL[i]];
      return r;
   endfunction

   function automatic logic [7:0] ip_inv(input logic [7:0] x);
      logic [7:0] r;
      r = '0;
      for (int i = 0; i < 8; i++) r[7-i] = x[8-IP_INV_TBL[i]];
      return r;
   endfunction

   function automatic logic [7:0] sw(input logic [7:0] x);
      return {x[3:0], x[7:4]};
   endfunction

endpackage

// File: rtl/sdes_fk.sv
// S-DES round function fK: (L, R) -> (L xor F(R, K), R). Purely combinational.
module sdes_fk
   import sdes_pkg::*;
(
   input  logic [7:0] data,
   input  logic [7:0] key,
   output logic [7:0] result
);

   logic [7:0] ep;
   logic [7:0] mixed;
   logic [3:0] sbox;
   logic [3:0] p4;

   always_comb begin
      ep = '0;
      p4 = '0;
      for (int i = 0; i < 8; i++) ep[7-i] = data[4-EP_TBL[i]];
      mixed = ep ^ key;
      sbox  = {S0_TBL[{mixed[7], mixed[4], mixed[6], mixed[5]}],
               S1_TBL[{mixed[3], mixed[0], mixed[2], mixed[1]}]};
      for (int i = 0; i < 4; i++) p4[3-i] = sbox[4-P4_TBL[i]];
      result = {data[7:4] ^ p4, data[3:0]};
   end

endmodule

// File: rtl/sdes_block_ctrl.sv
// S-DES sequencer: loads a key into the external key generator, latches K1/K2, then runs
// one block per four cycles. Define SDES_BLOCK_CNT_EN to add the blk_cnt completion counter.
module sdes_block_ctrl
   import sdes_pkg::*;
#(
   parameter int unsigned KEY_SETTLE = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       key_load,
   input  logic [9:0] key_in,
   output logic       key_ready,
   output logic [9:0] kg_key,
   output logic       kg_enable_n,
   input  logic [7:0] kg_k1,
   input  logic [7:0] kg_k2,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [7:0] in_data,
   input  logic       in_decrypt,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [7:0] out_data
`ifdef SDES_BLOCK_CNT_EN
   ,
   output logic [15:0] blk_cnt
`endif
);

   state_e     state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic [9:0] kg_key_q, kg_key_d;
   logic [7:0] k1_q, k1_d, k2_q, k2_d;
   logic [7:0] ka_q, ka_d, kb_q, kb_d;
   logic [7:0] data_q, data_d;
   logic [7:0] out_data_q, out_data_d;
   logic       key_accept;
   logic [7:0] fk_key, fk_out;

   sdes_fk u_fk (
      .data   (data_q),
      .key    (fk_key),
      .result (fk_out)
   );

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      kg_key_d   = kg_key_q;
      k1_d       = k1_q;
      k2_d       = k2_q;
      ka_d       = ka_q;
      kb_d       = kb_q;
      data_d     = data_q;
      out_data_d = out_data_q;
      key_accept = 1'b0;
      fk_key     = (state_q == StR1) ? ka_q : kb_q;

      unique case (state_q)
         StNoKey: key_accept = key_load;
         StKeyGen: begin
            if (cnt_q == 4'd1) begin
               k1_d    = kg_k1;
               k2_d    = kg_k2;
               state_d = StReady;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         StReady: begin
            // A key reload takes priority; in_ready is held low in that cycle.
            if (key_load) begin
               key_accept = 1'b1;
            end else if (in_valid) begin
               data_d  = ip(in_data);
               ka_d    = in_decrypt ? k2_q : k1_q;
               kb_d    = in_decrypt ? k1_q : k2_q;
               state_d = StR1;
            end
         end
         StR1: begin
            data_d  = sw(fk_out);
            state_d = StR2;
         end
         StR2: begin
            out_data_d = ip_inv(fk_out);
            state_d    = StDone;
         end
         StDone: if (out_ready) state_d = StReady;
         default: state_d = StNoKey;
      endcase

      if (key_accept) begin
         kg_key_d = key_in;
         cnt_d    = 4'(KEY_SETTLE);
         state_d  = StKeyGen;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StNoKey;
         cnt_q      <= '0;
         kg_key_q   <= '0;
         k1_q       <= '0;
         k2_q       <= '0;
         ka_q       <= '0;
         kb_q       <= '0;
         data_q     <= '0;
         out_data_q <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         kg_key_q   <= kg_key_d;
         k1_q       <= k1_d;
         k2_q       <= k2_d;
         ka_q       <= ka_d;
         kb_q       <= kb_d;
         data_q     <= data_d;
         out_data_q <= out_data_d;
      end
   end

   assign kg_key      = kg_key_q;
   assign kg_enable_n = (state_q != StKeyGen);
   assign key_ready   = state_q inside {StReady, StR1, StR2, StDone};
   assign in_ready    = (state_q == StReady) && !key_load;
   assign out_valid   = (state_q == StDone);
   assign out_data    = out_data_q;

`ifdef SDES_BLOCK_CNT_EN
   logic [15:0] blk_cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         blk_cnt_q <= '0;
      end else if (key_accept) begin
         blk_cnt_q <= '0;
      end else if (out_valid && out_ready && (blk_cnt_q != 16'hFFFF)) begin
         blk_cnt_q <= blk_cnt_q + 16'd1;
      end
   end

   assign blk_cnt = blk_cnt_q;
`endif

endmodule
